dadda_mult_arbiter: RTL and testbench
=====================================

# dadda_mult_arbiter

Shares one 16x16 `dadda` multiplier instance between NREQ independent requesters. Each requester has a valid/ready operand channel. The block grants one requester per cycle, registers the granted operands, runs them through the combinational Dadda/Brent-Kung datapath, and registers the 32-bit product. It returns the product on a single valid/ready response channel, tagged with the requester index. It is the sequencing and sharing layer between client logic and the multiplier, sustaining one product per cycle with 2-cycle latency.

## Interface

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, requester-index width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; asserts immediately, deasserts synchronously to clk.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  16*NREQ  multiplicand; requester i at bits [16i+15:16i].
- req_b  input  16*NREQ  multiplier; same packing as req_a.
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  downstream accept.
- rsp_prod  output  32  unsigned product a*b.
- rsp_id  output  IDW  index of the requester that issued the product.
- busy  output  1  s1_valid | s2_valid.

## Operation

Pipeline:
- S1 is the operand register: s1_valid, s1_a, s1_b, s1_id.
- The `dadda` instance is driven by s1_a and s1_b.
- S2 is the result register: s2_valid, s2_prod, s2_id.
- rsp_valid = s2_valid, rsp_prod = s2_prod, rsp_id = s2_id.

Flow control:
- s2_accept = !s2_valid | rsp_ready.
- s1_adv = s1_valid & s2_accept.
- s1_accept = !s1_valid | s1_adv.
- Arbitration produces grant (one-hot, from req_valid). req_ready = grant & {NREQ{s1_accept}}; req_ready is forced to 0 while rst is high.
- Transfer on requester i occurs when req_valid[i] & req_ready[i]. S1 loads that requester's operands and i, and sets s1_valid.
- When s1_adv is true, S2 loads the multiplier output and s1_id, and sets s2_valid.
- s1_valid clears when s1_adv is true and no new transfer occurs.
- s2_valid clears when rsp_ready is high and S1 is not advancing.
- Simultaneous response pop, S1 advance and new transfer is legal and keeps full throughput.

Requester rule:
- Once asserted, req_valid[i] and that requester's operands hold stable until transfer.
- Grant is re-evaluated every cycle, so grant may move between waiting requesters before a transfer.

Arbitration (see Configuration):
- Priority pointer ptr, IDW bits.
- Grant goes to the first asserting requester searching from ptr upward, wrapping past NREQ-1 to 0.
- On each transfer from requester g, ptr <= (g == NREQ-1) ? 0 : g+1.
- ptr holds when there is no transfer.

Arithmetic:
- Unsigned product only. The full 32-bit result always fits, so there is no overflow case.
- Maximum is 0xFFFF*0xFFFF = 0xFFFE0001.

Reset values:
- s1_valid, s2_valid = 0; ptr = 0; s1_a, s1_b, s2_prod = 0; s1_id, s2_id = 0.
- Outputs: rsp_valid = 0, rsp_prod = 0, rsp_id = 0, busy = 0, req_ready = 0.

Reset mid-operation: in-flight S1/S2 contents are discarded and no response is produced for them. Requesters must re-present their operands after reset.

## Timing

- Latency: a transfer at rising edge E0 produces rsp_valid high after E1 when S2 is not stalled (2 cycles, request to response).
- Throughput: 1 transfer per cycle while rsp_ready is held high.
- Backpressure:
  - With rsp_ready low, the pipeline holds 2 products: S2 and a pending S1.
  - req_ready drops to all-zero in the cycle after S1 fills behind a stalled S2.
  - The cycle rsp_ready returns high, S2 pops, S1 advances and one new transfer is accepted.
- rsp_prod and rsp_id are stable while rsp_valid & !rsp_ready.
- Critical path: S1 register -> dadda (partial products, reduction, BK adder) -> S2 register. The arbiter path req_valid -> req_ready is combinational and must not pass through the multiplier.

## Configuration

- DADDA_ARB_RR_EN defined: round-robin arbitration with rotating ptr, as described above.
- DADDA_ARB_RR_EN undefined: fixed priority, lowest asserting index wins. ptr and its register are removed, so a continuously asserting requester 0 may starve the others.
- The datapath, latency and handshake are identical in both builds.

## Test plan

- Single request: req 0, a=3, b=5, rsp_ready=1 -> req_ready[0] same cycle; rsp_valid after 2 edges with prod=15, id=0; busy returns to 0 the following cycle.
- Extremes: a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001; a=0x8000, b=0x0002 -> prod=0x00010000; a=0, b=0x1234 -> prod=0.
- Round-robin (RR_EN), all 4 requesters continuously valid with a=i+1, b=10, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 with prods 10,20,30,40 on consecutive cycles.
- Backpressure: 4 requests queued, rsp_ready=0 for 5 cycles -> exactly 2 transfers accepted; rsp_prod/rsp_id stable; req_ready all-zero; on release, remaining products arrive in grant order with no loss or duplication.
- Reset mid-flight: assert rst with S1 and S2 valid -> rsp_valid=0, busy=0, req_ready=0 immediately; after release the first new request returns a correct result and id with 2-cycle latency.
- Fixed priority (RR_EN undefined): req 0 and req 1 both continuously valid -> only id 0 is served for 10 cycles; dropping req 0 grants req 1 next cycle.

Source files
------------

// File: rtl/dadda_mult_arbiter.sv
// Shares one 16x16 Dadda/Brent-Kung multiplier between NREQ requesters (2-stage pipeline).
// DADDA_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority (index 0 highest).

module dadda (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] prod
);

    // Returns the two final rows {row1, row0} after Dadda reduction to height 2.
    // Bit k of col[c] is the k-th dot in column c; h[c] is that column's height.
    function automatic logic [63:0] dadda_reduce(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] col [32];
        logic [31:0] nxt [32];
        int          h   [32];
        int          nh  [32];
        int          k, rem, d, cn;
        logic [31:0] tmp;
        logic        s, cy;
        logic [31:0] r0, r1;
        for (int c = 0; c < 32; c++) begin
            col[c] = '0;
            h[c]   = 0;
        end
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                col[i+j] = col[i+j] | ({31'b0, x[i] & y[j]} << h[i+j]);
                h[i+j]   = h[i+j] + 1;
            end
        end
        for (int st = 0; st < 6; st++) begin
            d = (st == 0) ? 13 : (st == 1) ? 9 : (st == 2) ? 6 : (st == 3) ? 4 : (st == 4) ? 3 : 2;
            for (int c = 0; c < 32; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            for (int c = 0; c < 32; c++) begin
                k  = 0;
                cn = (c < 31) ? c + 1 : 31;
                for (int n = 0; n < 16; n++) begin
                    rem = h[c] - k;
                    if ((rem + nh[c] > d) && (rem >= 2)) begin
                        tmp = col[c] >> k;
                        if ((rem + nh[c] - d >= 2) && (rem >= 3)) begin
                            s  = tmp[0] ^ tmp[1] ^ tmp[2];
                            cy = (tmp[0] & tmp[1]) | (tmp[0] & tmp[2]) | (tmp[1] & tmp[2]);
                            k  = k + 3;
                        end else begin
                            s  = tmp[0] ^ tmp[1];
                            cy = tmp[0] & tmp[1];
                            k  = k + 2;
                        end
                        nxt[c] = nxt[c] | ({31'b0, s} << nh[c]);
                        nh[c]  = nh[c] + 1;
                        if (c < 31) begin
                            nxt[cn] = nxt[cn] | ({31'b0, cy} << nh[cn]);
                            nh[cn]  = nh[cn] + 1;
                        end
                    end
                end
                for (int n = 0; n < 16; n++) begin
                    if (k < h[c]) begin
                        tmp    = col[c] >> k;
                        nxt[c] = nxt[c] | ({31'b0, tmp[0]} << nh[c]);
                        nh[c]  = nh[c] + 1;
                        k      = k + 1;
                    end
                end
            end
            for (int c = 0; c < 32; c++) begin
                col[c] = nxt[c];
                h[c]   = nh[c];
            end
        end
        for (int c = 0; c < 32; c++) begin
            tmp   = col[c];
            r0[c] = tmp[0];
            r1[c] = tmp[1];
        end
        return {r1, r0};
    endfunction

    logic [63:0] rows;
    logic [31:0] op_x, op_y, g, p, gg, pp;
    int          j;

    always_comb begin
        rows = dadda_reduce(a, b);
        op_x = rows[31:0];
        op_y = rows[63:32];
        g    = op_x & op_y;
        p    = op_x ^ op_y;
        gg   = g;
        pp   = p;
        j    = 0;
        // Brent-Kung prefix: up-sweep builds power-of-two spans, down-sweep fills the rest
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    j     = (i >= (1 << l)) ? i - (1 << l) : 0;
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                    pp[i] = pp[i] & pp[j];
                end
            end
        end
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 32; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    j     = i - (1 << l);
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                    pp[i] = pp[i] & pp[j];
                end
            end
        end
        prod = p ^ {gg[30:0], 1'b0};
    end

endmodule

module dadda_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_prod,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    logic            s1_valid_q, s1_valid_d;
    logic [15:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [31:0]     s2_prod_q, s2_prod_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;
    logic [31:0]     mult_prod;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic [15:0]     gnt_a, gnt_b;
    logic            found, xfer, s2_accept, s1_adv, s1_accept;

`ifdef DADDA_ARB_RR_EN
    logic [IDW-1:0]  ptr_q, ptr_d;
`endif

    dadda u_dadda (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .prod (mult_prod)
    );

    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
`ifdef DADDA_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i == ((int'(ptr_q) + k) % NREQ))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gid      = IDW'(i);
                end
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gid      = IDW'(i);
            end
        end
`endif
    end

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_a = req_a[16*i +: 16];
                gnt_b = req_b[16*i +: 16];
            end
        end
    end

    assign s2_accept = !s2_valid_q || rsp_ready;
    assign s1_adv    = s1_valid_q && s2_accept;
    assign s1_accept = !s1_valid_q || s1_adv;
    assign req_ready = rst ? '0 : (grant & {NREQ{s1_accept}});
    assign xfer      = |req_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_id_d    = s2_id_q;
        if (xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = gnt_a;
            s1_b_d     = gnt_b;
            s1_id_d    = gid;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_prod_d  = mult_prod;
            s2_id_d    = s1_id_q;
        end else if (rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

`ifdef DADDA_ARB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            if (int'(gid) == NREQ - 1) ptr_d = '0;
            else                       ptr_d = gid + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_prod  = s2_prod_q;
    assign rsp_id    = s2_id_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_dadda_mult_arbiter.sv
// Directed testbench for dadda_mult_arbiter (NREQ=4); checks either arbitration build.
module tb_dadda_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_prod;
    logic [1:0]  rsp_id;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    dadda_mult_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        chk("drain_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic single(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] p);
        req_a     = (req_a & ~(64'hFFFF << (16 * id))) | ({48'b0, a} << (16 * id));
        req_b     = (req_b & ~(64'hFFFF << (16 * id))) | ({48'b0, b} << (16 * id));
        req_valid = 4'b1 << id;
        rsp_ready = 1'b1;
        #1;
        chk("single_ready", {28'b0, req_ready}, {28'b0, 4'b1 << id});
        tick();
        req_valid = 4'b0;
        chk("single_s1_busy", {31'b0, busy}, 32'd1);
        chk("single_s1_novalid", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("single_valid", {31'b0, rsp_valid}, 32'd1);
        chk("single_prod", rsp_prod, p);
        chk("single_id", {30'b0, rsp_id}, id);
        tick();
        chk("single_busy_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0]  exp_id [5];
        logic [31:0] exp_pr [5];
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_pr = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd10};

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #23;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_prod", rsp_prod, 32'd0);
        chk("rst_rsp_id", {30'b0, rsp_id}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
        req_valid = 4'b0;
        tick();
        rst = 1'b0;
        tick();

        single(0, 16'd3, 16'd5, 32'd15);
        single(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        single(2, 16'h8000, 16'h0002, 32'h00010000);
        single(3, 16'h0000, 16'h1234, 32'h00000000);

        req_a     = {16'd4, 16'd3, 16'd2, 16'd1};
        req_b     = {16'd10, 16'd10, 16'd10, 16'd10};
        rsp_ready = 1'b1;
`ifdef DADDA_ARB_RR_EN
        req_valid = 4'b1111;
        #1;
        chk("rr_first_ready", {28'b0, req_ready}, 32'd1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("rr_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rr_id", {30'b0, rsp_id}, {30'b0, exp_id[k]});
            chk("rr_prod", rsp_prod, exp_pr[k]);
            tick();
        end
        req_valid = 4'b0;
`else
        req_valid = 4'b0011;
        #1;
        chk("fp_first_ready", {28'b0, req_ready}, 32'd1);
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("fp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("fp_id", {30'b0, rsp_id}, 32'd0);
            chk("fp_prod", rsp_prod, 32'd10);
            chk("fp_ready", {28'b0, req_ready}, 32'd1);
            tick();
        end
        req_valid = 4'b0010;
        #1;
        chk("fp_switch_ready", {28'b0, req_ready}, 32'd2);
        tick();
        req_valid = 4'b0;
        chk("fp_tail_id0", {30'b0, rsp_id}, 32'd0);
        tick();
        chk("fp_req1_id", {30'b0, rsp_id}, 32'd1);
        chk("fp_req1_prod", rsp_prod, 32'd20);
`endif
        drain();

        // reset with both stages occupied
        rsp_ready = 1'b0;
        req_a     = {16'd0, 16'd0, 16'd7, 16'd9};
        req_b     = {16'd0, 16'd0, 16'd7, 16'd9};
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = 4'b0;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("mid_rsp_prod", rsp_prod, 32'd81);
        rst       = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("mrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_req_ready", {28'b0, req_ready}, 32'd0);
        chk("mrst_rsp_prod", rsp_prod, 32'd0);
        tick();
        rst       = 1'b0;
        req_valid = 4'b0;
        single(3, 16'h00FF, 16'h0101, 32'h0000FFFF);

        // backpressure: four queued requests, response stalled
        req_a     = {16'd5, 16'd4, 16'd3, 16'd2};
        req_b     = {16'd7, 16'd7, 16'd7, 16'd7};
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("bp_ready0", {28'b0, req_ready}, 32'd1);
        tick();
        req_valid = 4'b1110;
        #1;
        chk("bp_ready1", {28'b0, req_ready}, 32'd2);
        tick();
        req_valid = 4'b1100;
        #1;
        chk("bp_full_ready", {28'b0, req_ready}, 32'd0);
        chk("bp_full_id", {30'b0, rsp_id}, 32'd0);
        chk("bp_full_prod", rsp_prod, 32'd14);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_hold_prod", rsp_prod, 32'd14);
            chk("bp_hold_id", {30'b0, rsp_id}, 32'd0);
            chk("bp_hold_ready", {28'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'b0, req_ready}, 32'd4);
        tick();
        req_valid = 4'b1000;
        #1;
        chk("bp_r1_id", {30'b0, rsp_id}, 32'd1);
        chk("bp_r1_prod", rsp_prod, 32'd21);
        chk("bp_r3_ready", {28'b0, req_ready}, 32'd8);
        tick();
        req_valid = 4'b0;
        #1;
        chk("bp_r2_id", {30'b0, rsp_id}, 32'd2);
        chk("bp_r2_prod", rsp_prod, 32'd28);
        tick();
        chk("bp_r3_id", {30'b0, rsp_id}, 32'd3);
        chk("bp_r3_prod", rsp_prod, 32'd35);
        chk("bp_r3_valid", {31'b0, rsp_valid}, 32'd1);
        tick();
        chk("bp_empty_valid", {31'b0, rsp_valid}, 32'd0);
        chk("bp_empty_busy", {31'b0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
